lift_call_scheduler: RTL

LIFT_CALL_SCHEDULER -- requirements
Module: lift_call_scheduler

---
 rtl/lift_call_scheduler_pkg.sv | 14 +
 rtl/lift_call_scheduler_scan.sv | 64 ++++++
 rtl/lift_call_scheduler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/lift_call_scheduler_pkg.sv
// Shared types and constants for the lift call scheduler.
package lift_call_scheduler_pkg;

  localparam int unsigned FLOOR_W          = 6;
  localparam int unsigned DEF_NUM_FLOORS   = 16;
  localparam int unsigned DEF_DWELL_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAVEL = 2'd1,
    DWELL  = 2'd2
  } state_t;

endpackage

// File: rtl/lift_call_scheduler_scan.sv
// SCAN target selection: nearest pending floor in the sweep direction, else reverse.
module lift_scan_select
  import lift_call_scheduler_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = DEF_NUM_FLOORS
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  dir_up,
  output logic [FLOOR_W-1:0]    target,
  output logic                  valid,
  output logic                  new_dir
);

  logic [FLOOR_W-1:0] up_t, dn_t;
  logic               up_v, dn_v;

  always_comb begin
    up_t = '0;
    dn_t = '0;
    up_v = 1'b0;
    dn_v = 1'b0;
    // Ascending scan: last hit below cur_floor is the highest one below.
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (FLOOR_W'(i) < cur_floor)) begin
        dn_t = FLOOR_W'(i);
        dn_v = 1'b1;
      end
    end
    // Descending scan: last hit above cur_floor is the lowest one above.
    for (int unsigned i = NUM_FLOORS; i > 0; i--) begin
      if (pending[i-1] && (FLOOR_W'(i-1) > cur_floor)) begin
        up_t = FLOOR_W'(i-1);
        up_v = 1'b1;
      end
    end
  end

  always_comb begin
    target  = '0;
    valid   = 1'b0;
    new_dir = dir_up;
    if (dir_up) begin
      if (up_v) begin
        target = up_t;
        valid  = 1'b1;
      end else if (dn_v) begin
        target  = dn_t;
        valid   = 1'b1;
        new_dir = 1'b0;
      end
    end else begin
      if (dn_v) begin
        target = dn_t;
        valid  = 1'b1;
      end else if (up_v) begin
        target  = up_t;
        valid   = 1'b1;
        new_dir = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lift_call_scheduler.sv
// Latches floor calls and schedules lift targets with a SCAN sweep and door dwell.
module lift_call_scheduler
  import lift_call_scheduler_pkg::*;
#(
  parameter int unsigned NUM_FLOORS   = DEF_NUM_FLOORS,
  parameter int unsigned DWELL_CYCLES = DEF_DWELL_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  lift_stop,
  output logic [FLOOR_W-1:0]    req_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  busy,
  output logic                  served
);

  state_t                state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_d, set_mask, clr_mask, eff, cur_mask;
  logic [FLOOR_W-1:0]    target_q, target_d, sel_target;
  logic [7:0]            cnt_q, cnt_d;
  logic                  dir_d, served_d, sel_valid, sel_dir, cur_ok, at_cur;

  assign cur_ok   = cur_floor < FLOOR_W'(NUM_FLOORS);
  assign cur_mask = NUM_FLOORS'(1) << cur_floor;
  assign set_mask = (state_q == DWELL) ? (call_btn & ~cur_mask) : call_btn;
  // Decisions see this cycle's accepted presses so a call acts at the edge it latches.
  assign eff      = pending | set_mask;
  assign at_cur   = |(eff & cur_mask);

  lift_scan_select #(.NUM_FLOORS(NUM_FLOORS)) u_scan (
    .pending   (eff),
    .cur_floor (cur_floor),
    .dir_up    (dir_up),
    .target    (sel_target),
    .valid     (sel_valid),
    .new_dir   (sel_dir)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pending  <= '0;
      dir_up   <= 1'b1;
      target_q <= '0;
      cnt_q    <= '0;
      served   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pending  <= pending_d;
      dir_up   <= dir_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      served   <= served_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_up;
    target_d = target_q;
    cnt_d    = cnt_q;
    served_d = 1'b0;
    clr_mask = '0;
    if (!cur_ok) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (at_cur && lift_stop) begin
            state_d = DWELL;
          end else if (sel_valid) begin
            state_d  = TRAVEL;
            target_d = sel_target;
            dir_d    = sel_dir;
          end
        end
        TRAVEL: begin
          if ((cur_floor == target_q) && lift_stop) begin
            state_d = DWELL;
          end else if (sel_valid && (sel_dir == dir_up) &&
                       (dir_up ? (sel_target < target_q) : (sel_target > target_q))) begin
            target_d = sel_target;
          end
        end
        DWELL: begin
          if (cnt_q == 8'd0) begin
            if (sel_valid) begin
              state_d  = TRAVEL;
              target_d = sel_target;
              dir_d    = sel_dir;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if ((state_d == DWELL) && (state_q != DWELL)) begin
      clr_mask = cur_mask;
      served_d = 1'b1;
      cnt_d    = 8'(DWELL_CYCLES - 1);
    end
    pending_d = eff & ~clr_mask;
  end

  always_comb begin
    busy = (state_q != IDLE);
    if (!reset || !cur_ok) begin
      req_floor = '0;
    end else if (state_q == TRAVEL) begin
      req_floor = target_q;
    end else begin
      req_floor = cur_floor;
    end
  end

endmodule
